// File: rtl/csr_defs.sv
// Shared CSR address map, field positions and exception codes for the CSR register file.
package csr_defs;

    localparam logic [13:0] CSR_CRMD   = 14'h0000;
    localparam logic [13:0] CSR_PRMD   = 14'h0001;
    localparam logic [13:0] CSR_ECFG   = 14'h0004;
    localparam logic [13:0] CSR_ESTAT  = 14'h0005;
    localparam logic [13:0] CSR_ERA    = 14'h0006;
    localparam logic [13:0] CSR_BADV   = 14'h0007;
    localparam logic [13:0] CSR_EENTRY = 14'h000C;
    localparam logic [13:0] CSR_SAVE0  = 14'h0030;
    localparam logic [13:0] CSR_SAVE1  = 14'h0031;
    localparam logic [13:0] CSR_SAVE2  = 14'h0032;
    localparam logic [13:0] CSR_SAVE3  = 14'h0033;
    localparam logic [13:0] CSR_TID    = 14'h0040;
    localparam logic [13:0] CSR_TCFG   = 14'h0041;
    localparam logic [13:0] CSR_TVAL   = 14'h0042;
    localparam logic [13:0] CSR_TICLR  = 14'h0044;

    localparam int CRMD_PLV_LO     = 0;
    localparam int CRMD_PLV_HI     = 1;
    localparam int CRMD_IE         = 2;
    localparam int CRMD_DA         = 3;
    localparam int CRMD_PG         = 4;
    localparam int CRMD_DATF_LO    = 5;
    localparam int CRMD_DATF_HI    = 6;
    localparam int CRMD_DATM_LO    = 7;
    localparam int CRMD_DATM_HI    = 8;
    localparam int PRMD_PPLV_LO    = 0;
    localparam int PRMD_PPLV_HI    = 1;
    localparam int PRMD_PIE        = 2;
    localparam int ESTAT_IS_LO     = 0;
    localparam int ESTAT_IS_HI     = 12;
    localparam int ESTAT_ECODE_LO  = 16;
    localparam int ESTAT_ECODE_HI  = 21;
    localparam int ESTAT_ESUB_LO   = 22;
    localparam int ESTAT_ESUB_HI   = 30;
    localparam int IS_SW_HI        = 1;
    localparam int IS_HW_LO        = 2;
    localparam int IS_HW_HI        = 9;
    localparam int IS_TIMER        = 11;
    localparam int IS_IPI          = 12;
    localparam int TCFG_EN         = 0;
    localparam int TCFG_PERIODIC   = 1;
    localparam int TCFG_INITVAL_LO = 2;

    localparam logic [12:0] LIE_MASK = 13'h1BFF;

    localparam logic [5:0] ECODE_INT  = 6'h00;
    localparam logic [5:0] ECODE_ADEF = 6'h08;
    localparam logic [5:0] ECODE_ALE  = 6'h09;
    localparam logic [5:0] ECODE_SYS  = 6'h0B;

    function automatic logic [31:0] csr_merge(input logic [31:0] old_val,
                                              input logic [31:0] wvalue,
                                              input logic [31:0] wmask);
        return (old_val & ~wmask) | (wvalue & wmask);
    endfunction

endpackage

// File: rtl/csr_timer.sv
// Interrupt timer: holds TCFG and TVAL, and raises/clears the timer interrupt request.
module csr_timer #(
    parameter int TIMER_W = 32
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               tcfg_we,
    input  logic [TIMER_W-1:0] tcfg_wdata,
    input  logic               ticlr_we,
    input  logic               ticlr_wbit,
    output logic [TIMER_W-1:0] tcfg,
    output logic [TIMER_W-1:0] tval,
    output logic               timer_int_set,
    output logic               timer_int_clr
);
    import csr_defs::*;

    localparam logic [TIMER_W-1:0] TVAL_IDLE = {TIMER_W{1'b1}};

    logic [TIMER_W-1:0] tcfg_r;
    logic [TIMER_W-1:0] tval_r;
    logic [TIMER_W-1:0] tval_next_s;
    logic [TIMER_W-1:0] reload_s;
    logic [TIMER_W-1:0] arm_val_s;
    logic               expire_s;

    assign reload_s  = {tcfg_r[TIMER_W-1:TCFG_INITVAL_LO], 2'b00};
    assign arm_val_s = {tcfg_wdata[TIMER_W-1:TCFG_INITVAL_LO], 2'b00};
    assign expire_s  = tcfg_r[TCFG_EN] && (tval_r == {TIMER_W{1'b0}});

    // Next TVAL: arming beats expiry beats counting; all-ones means halted.
    always_comb begin
        tval_next_s = tval_r;
        if (tcfg_we && tcfg_wdata[TCFG_EN]) begin
            tval_next_s = arm_val_s;
        end else if (expire_s) begin
            tval_next_s = tcfg_r[TCFG_PERIODIC] ? reload_s : TVAL_IDLE;
        end else if (tcfg_r[TCFG_EN] && (tval_r != TVAL_IDLE)) begin
            tval_next_s = tval_r - {{(TIMER_W-1){1'b0}}, 1'b1};
        end else begin
            tval_next_s = tval_r;
        end
    end

    // Timer configuration and count registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            tcfg_r <= {TIMER_W{1'b0}};
            tval_r <= TVAL_IDLE;
        end else begin
            if (tcfg_we) begin
                tcfg_r <= tcfg_wdata;
            end
            tval_r <= tval_next_s;
        end
    end

    assign tcfg          = tcfg_r;
    assign tval          = tval_r;
    assign timer_int_set = expire_s;
    assign timer_int_clr = ticlr_we && ticlr_wbit;

endmodule

// File: rtl/csr_regfile.sv
// CSR register file: software CSR access, exception entry/return bookkeeping,
// interrupt status sampling and the pending-interrupt flag.
module csr_regfile #(
    parameter logic [31:0] EENTRY_RST = 32'h0000_0000,
    parameter int          TIMER_W    = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        csr_re,
    input  logic [13:0] csr_num,
    output logic [31:0] csr_rvalue,
    input  logic        csr_we,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    input  logic        wb_ex,
    input  logic [5:0]  wb_ecode,
    input  logic [8:0]  wb_esubcode,
    input  logic [31:0] wb_pc,
    input  logic [31:0] wb_vaddr,
    input  logic        ertn_flush,
    input  logic [7:0]  hw_int_in,
    input  logic        ipi_int_in,
    input  logic [31:0] coreid_in,
    output logic [31:0] ex_entry,
    output logic [31:0] ertn_entry,
    output logic        has_int
);
    import csr_defs::*;

    logic [1:0]  crmd_plv_r;
    logic        crmd_ie_r;
    logic        crmd_da_r;
    logic        crmd_pg_r;
    logic [1:0]  crmd_datf_r;
    logic [1:0]  crmd_datm_r;
    logic [1:0]  prmd_pplv_r;
    logic        prmd_pie_r;
    logic [12:0] ecfg_lie_r;
    logic [12:0] estat_is_r;
    logic [5:0]  estat_ecode_r;
    logic [8:0]  estat_esub_r;
    logic [31:0] era_r;
    logic [31:0] badv_r;
    logic [25:0] eentry_va_r;
    logic [31:0] save_r [0:3];
    logic [31:0] tid_r;

    logic               sw_we_s;
    logic               badv_hit_s;
    logic [31:0]        cur_val_s;
    logic [31:0]        merged_s;
    logic [TIMER_W-1:0] tcfg_s;
    logic [TIMER_W-1:0] tval_s;
    logic               timer_int_set_s;
    logic               timer_int_clr_s;

    // Exception entry and ERTN both squash a software write in the same cycle.
    assign sw_we_s    = csr_we && !wb_ex && !ertn_flush;
    assign badv_hit_s = (wb_ecode == ECODE_ADEF) || (wb_ecode == ECODE_ALE);
    assign merged_s   = csr_merge(cur_val_s, csr_wvalue, csr_wmask);

    // Architectural view of the addressed CSR; also the "old" value for masked writes.
    always_comb begin
        cur_val_s = 32'h0000_0000;
        case (csr_num)
            CSR_CRMD:   cur_val_s = {23'h000000, crmd_datm_r, crmd_datf_r, crmd_pg_r,
                                     crmd_da_r, crmd_ie_r, crmd_plv_r};
            CSR_PRMD:   cur_val_s = {29'h00000000, prmd_pie_r, prmd_pplv_r};
            CSR_ECFG:   cur_val_s = {19'h00000, ecfg_lie_r};
            CSR_ESTAT:  cur_val_s = {1'b0, estat_esub_r, estat_ecode_r, 3'b000, estat_is_r};
            CSR_ERA:    cur_val_s = era_r;
            CSR_BADV:   cur_val_s = badv_r;
            CSR_EENTRY: cur_val_s = {eentry_va_r, 6'b000000};
            CSR_SAVE0:  cur_val_s = save_r[0];
            CSR_SAVE1:  cur_val_s = save_r[1];
            CSR_SAVE2:  cur_val_s = save_r[2];
            CSR_SAVE3:  cur_val_s = save_r[3];
            CSR_TID:    cur_val_s = tid_r;
            CSR_TCFG:   cur_val_s = 32'(tcfg_s);
            CSR_TVAL:   cur_val_s = 32'(tval_s);
            default:    cur_val_s = 32'h0000_0000;
        endcase
    end

    assign csr_rvalue = csr_re ? cur_val_s : 32'h0000_0000;

    // CRMD/PRMD: exception entry saves and clears privilege state, ERTN restores it.
    always_ff @(posedge clk) begin
        if (reset) begin
            crmd_plv_r  <= 2'b00;
            crmd_ie_r   <= 1'b0;
            crmd_da_r   <= 1'b1;
            crmd_pg_r   <= 1'b0;
            crmd_datf_r <= 2'b00;
            crmd_datm_r <= 2'b00;
            prmd_pplv_r <= 2'b00;
            prmd_pie_r  <= 1'b0;
        end else if (wb_ex) begin
            prmd_pplv_r <= crmd_plv_r;
            prmd_pie_r  <= crmd_ie_r;
            crmd_plv_r  <= 2'b00;
            crmd_ie_r   <= 1'b0;
        end else if (ertn_flush) begin
            crmd_plv_r <= prmd_pplv_r;
            crmd_ie_r  <= prmd_pie_r;
        end else if (sw_we_s) begin
            case (csr_num)
                CSR_CRMD: begin
                    crmd_plv_r  <= merged_s[CRMD_PLV_HI:CRMD_PLV_LO];
                    crmd_ie_r   <= merged_s[CRMD_IE];
                    crmd_da_r   <= merged_s[CRMD_DA];
                    crmd_pg_r   <= merged_s[CRMD_PG];
                    crmd_datf_r <= merged_s[CRMD_DATF_HI:CRMD_DATF_LO];
                    crmd_datm_r <= merged_s[CRMD_DATM_HI:CRMD_DATM_LO];
                end
                CSR_PRMD: begin
                    prmd_pplv_r <= merged_s[PRMD_PPLV_HI:PRMD_PPLV_LO];
                    prmd_pie_r  <= merged_s[PRMD_PIE];
                end
                default: begin
                end
            endcase
        end
    end

    // Exception record: ERA, cause code and, for address faults only, BADV.
    always_ff @(posedge clk) begin
        if (reset) begin
            era_r         <= 32'h0000_0000;
            badv_r        <= 32'h0000_0000;
            estat_ecode_r <= 6'h00;
            estat_esub_r  <= 9'h000;
        end else if (wb_ex) begin
            era_r         <= wb_pc;
            estat_ecode_r <= wb_ecode;
            estat_esub_r  <= wb_esubcode;
            if (badv_hit_s) begin
                badv_r <= wb_vaddr;
            end
        end else if (sw_we_s) begin
            case (csr_num)
                CSR_ERA:  era_r  <= merged_s;
                CSR_BADV: badv_r <= merged_s;
                default: begin
                end
            endcase
        end
    end

    // Interrupt status: hardware lines sampled every cycle; timer set beats TICLR clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            estat_is_r <= 13'h0000;
        end else begin
            estat_is_r[IS_HW_HI:IS_HW_LO] <= hw_int_in;
            estat_is_r[IS_IPI]            <= ipi_int_in;
            if (timer_int_set_s) begin
                estat_is_r[IS_TIMER] <= 1'b1;
            end else if (timer_int_clr_s) begin
                estat_is_r[IS_TIMER] <= 1'b0;
            end
            if (sw_we_s && (csr_num == CSR_ESTAT)) begin
                estat_is_r[IS_SW_HI:ESTAT_IS_LO] <= merged_s[IS_SW_HI:ESTAT_IS_LO];
            end
        end
    end

    // Plain software-owned registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            ecfg_lie_r  <= 13'h0000;
            eentry_va_r <= EENTRY_RST[31:6];
            tid_r       <= coreid_in;
            for (int i = 0; i < 4; i++) begin
                save_r[i] <= 32'h0000_0000;
            end
        end else if (sw_we_s) begin
            case (csr_num)
                CSR_ECFG:   ecfg_lie_r  <= merged_s[12:0] & LIE_MASK;
                CSR_EENTRY: eentry_va_r <= merged_s[31:6];
                CSR_SAVE0:  save_r[0]   <= merged_s;
                CSR_SAVE1:  save_r[1]   <= merged_s;
                CSR_SAVE2:  save_r[2]   <= merged_s;
                CSR_SAVE3:  save_r[3]   <= merged_s;
                CSR_TID:    tid_r       <= merged_s;
                default: begin
                end
            endcase
        end
    end

    csr_timer #(
        .TIMER_W (TIMER_W)
    ) u_timer (
        .clk           (clk),
        .reset         (reset),
        .tcfg_we       (sw_we_s && (csr_num == CSR_TCFG)),
        .tcfg_wdata    (merged_s[TIMER_W-1:0]),
        .ticlr_we      (sw_we_s && (csr_num == CSR_TICLR)),
        .ticlr_wbit    (merged_s[0]),
        .tcfg          (tcfg_s),
        .tval          (tval_s),
        .timer_int_set (timer_int_set_s),
        .timer_int_clr (timer_int_clr_s)
    );

    assign ex_entry   = {eentry_va_r, 6'b000000};
    assign ertn_entry = era_r;
    assign has_int    = crmd_ie_r && (|(estat_is_r & ecfg_lie_r));

endmodule
